cars_lane_array: RTL

- Parametrised multi-lane traffic generator for the road-crossing game.
- Holds LANES independent occupancy vectors, each WIDTH columns wide, and moves cars one column per lane-step.
- Each lane has its own direction and speed. New cars enter from a manual trigger or from a shared LFSR, subject to a minimum-gap rule.
- Detects player/car overlap and freezes the road; the LED-matrix driver and game controller sit downstream.

---
 rtl/cars_lane_array.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cars_lane_array.sv
// cars_lane_array: multi-lane car generator with per-lane speed/direction,
// manual and LFSR-driven spawning, an entry gap rule and a collision freeze.
module cars_lane_array #(
    parameter int          WIDTH   = 16,
    parameter int          LANES   = 4,
    parameter int          SPEED_W = 4,
    parameter int          MIN_GAP = 2,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int unsigned PL_W   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned CL_W   = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     hardReset,
    input  logic                     tick,
    input  logic                     en,
    input  logic                     clear,
    input  logic [LANES-1:0]         dir,
    input  logic [LANES*SPEED_W-1:0] speed,
    input  logic [LANES-1:0]         trigger,
    input  logic                     rand_en,
    input  logic [3:0]               density,
    input  logic [PL_W-1:0]          player_lane,
    input  logic [CL_W-1:0]          player_col,
    output logic [LANES*WIDTH-1:0]   lanes_out,
    output logic                     hit
);

    localparam logic [1:0] ST_STOP   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_hit;
    logic [15:0]        r_lfsr;
    logic [WIDTH-1:0]   r_lane     [LANES];
    logic [SPEED_W-1:0] r_cnt      [LANES];
    logic [LANES-1:0]   r_pend;
    logic [WIDTH-1:0]   w_lane_nxt [LANES];
    logic [SPEED_W-1:0] w_cnt_nxt  [LANES];
    logic [LANES-1:0]   w_pend_nxt;
    logic               w_collide;
    logic               w_advance;

    // Player/car overlap on the registered road; out-of-range lanes match nothing
    always_comb begin
        w_collide = 1'b0;
        if (r_state == ST_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if ((player_lane == PL_W'(i)) && (player_col == CL_W'(c)) && r_lane[i][c]) begin
                        w_collide = 1'b1;
                    end
                end
            end
        end
    end

    // A collision takes priority over the step on the same edge
    assign w_advance = (r_state == ST_RUN) && tick && !w_collide;

    // Next-state logic; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_STOP;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (en) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_collide)  w_state_nxt = ST_FROZEN;
                    else if (!en)   w_state_nxt = ST_STOP;
                end
                ST_FROZEN: begin
                    w_state_nxt = ST_FROZEN;
                end
                default: begin
                    w_state_nxt = ST_STOP;
                end
            endcase
        end
    end

    // State register; hit mirrors the FROZEN state
    always_ff @(posedge clk or negedge hardReset) begin
        if (!hardReset) begin
            r_state <= ST_STOP;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hit   <= (w_state_nxt == ST_FROZEN);
        end
    end

    // Shared Galois LFSR, stepped by every tick whatever the state
    always_ff @(posedge clk or negedge hardReset) begin
        if (!hardReset) begin
            r_lfsr <= SEED;
        end else if (tick) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Per-lane divider, shift, spawn decision and pending-trigger bookkeeping
    always_comb begin
        logic [SPEED_W-1:0] v_speed;
        logic [3:0]         v_rnd;
        logic               v_step;
        logic               v_busy;
        logic               v_req;
        logic               v_ins;
        logic [WIDTH-1:0]   v_shift;
        logic [WIDTH-1:0]   v_entry;
        v_speed    = '0;
        v_rnd      = '0;
        v_step     = 1'b0;
        v_busy     = 1'b0;
        v_req      = 1'b0;
        v_ins      = 1'b0;
        v_shift    = '0;
        v_entry    = '0;
        w_pend_nxt = r_pend;
        for (int i = 0; i < LANES; i++) begin
            v_speed = speed[i*SPEED_W +: SPEED_W];
            v_rnd   = r_lfsr[4*(i%4) +: 4];
            // cnt above a freshly lowered speed counts as reached
            v_step  = w_advance && (r_cnt[i] >= v_speed);
            v_busy  = 1'b0;
            for (int g = 0; g < MIN_GAP; g++) begin
                if (dir[i]) v_busy = v_busy | r_lane[i][g];
                else        v_busy = v_busy | r_lane[i][WIDTH-1-g];
            end
            v_req   = r_pend[i] || (rand_en && (v_rnd < density));
            v_ins   = v_step && v_req && !v_busy;
            v_shift = dir[i] ? (r_lane[i] << 1) : (r_lane[i] >> 1);
            v_entry = dir[i] ? WIDTH'(1) : {1'b1, {(WIDTH-1){1'b0}}};

            w_cnt_nxt[i] = r_cnt[i];
            if (w_advance) w_cnt_nxt[i] = v_step ? '0 : SPEED_W'(r_cnt[i] + 1'b1);

            w_lane_nxt[i] = r_lane[i];
            if (v_step) w_lane_nxt[i] = v_shift | (v_ins ? v_entry : '0);

            // an insertion swallows a trigger arriving on the same edge
            w_pend_nxt[i] = v_ins ? 1'b0 : (r_pend[i] | trigger[i]);
        end
    end

    // Road, divider and pending registers; clear wipes them but not the LFSR
    always_ff @(posedge clk or negedge hardReset) begin
        if (!hardReset) begin
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_pend <= '0;
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= w_lane_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
            end
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_out
        assign lanes_out[gi*WIDTH +: WIDTH] = r_lane[gi];
    end

    assign hit = r_hit;

endmodule
